// File: rtl/spi_mem_streamer.sv
// SPI mode-0 master that streams a burst of memory words out on mosi, one word per fetch.
// Optional macro SPI_STREAM_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_mem_streamer #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 5,
    parameter int MEM_DEPTH = 16,
    parameter int CLK_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_SHIFT = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and output registers; reset forces the SPI bus idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            rem_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            rem_q      <= rem_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; outputs land one cycle after the state acts.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        rem_d      = rem_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done_q high means we are in the pulse cycle; a start there is dropped.
                if (start && !done_q) begin
                    busy_d = 1'b1;
                    rem_d  = word_count;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = ADDR_W'(start_addr % MEM_DEPTH);
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_LOAD;
            S_LOAD: begin
                shift_d   = mem_rdata;
                cs_n_d    = 1'b0;
                sclk_d    = 1'b0;
                bit_cnt_d = '0;
                div_cnt_d = '0;
`ifdef SPI_STREAM_LSB_FIRST_EN
                mosi_d    = mem_rdata[0];
`else
                mosi_d    = mem_rdata[DATA_W-1];
`endif
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            rem_d = rem_q - ADDR_W'(1);
                            if (rem_q > ADDR_W'(1)) begin
                                if (mem_addr_q == ADDR_TOP) begin
                                    mem_addr_d = '0;
                                end else begin
                                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                                end
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
`ifdef SPI_STREAM_LSB_FIRST_EN
                            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                            mosi_d    = shift_q[1];
`else
                            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                            mosi_d    = shift_q[DATA_W-2];
`endif
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign mem_we   = 1'b0;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/spi_mem_streamer.md
Name: spi_mem_streamer

Overview:
- SPI master transmitter that reads a burst of 24-bit words from the 16-entry data memory and shifts them out MSB-first in SPI mode 0 (CPOL=0, CPHA=0).
- It sits between the data memory read port and the off-chip SPI pins, and is the reading end of the memory interface.
- A burst is started by a one-cycle start request. The block holds cs_n low for the whole burst and pulses done when the burst ends.

Parameters:
- DATA_W, 24, memory word width and bits shifted per word
- ADDR_W, 5, memory address width
- MEM_DEPTH, 16, number of valid memory entries; the address wraps modulo this value
- CLK_DIV, 4, number of clk cycles per sclk half-period (sclk period = 2*CLK_DIV clk cycles); must be >= 1

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  burst request, sampled only in IDLE
- start_addr  input  ADDR_W  first memory address of the burst
- word_count  input  ADDR_W  number of words to send, 0..31
- mem_addr  output  ADDR_W  memory address, registered
- mem_we  output  1  memory write enable, constant 0
- mem_rdata  input  DATA_W  memory read data (synchronous read, 1-cycle latency)
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out
- cs_n  output  1  SPI chip select, active-low
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, mem_addr=0, mem_we=0, internal counters=0. Deassertion is used synchronously.
- States and transitions:
  - IDLE: start=1 latches start_addr and word_count and sets busy=1. If word_count=0, go to DONE. Otherwise drive mem_addr=start_addr and go to FETCH.
  - FETCH: 1 cycle; the memory samples mem_addr.
  - WAIT: 1 cycle; mem_rdata becomes valid.
  - LOAD: shift_reg <= mem_rdata; cs_n=0; mosi=mem_rdata[DATA_W-1]; bit_cnt=0; go to SHIFT.
  - SHIFT:
    - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; mosi is stable through both phases. The slave samples on the rising edge.
    - On the falling edge that ends bit n (n < DATA_W-1), mosi changes to the next bit.
    - After bit DATA_W-1 the high phase ends with sclk=0. Then decrement the remaining count.
    - If remaining > 0: mem_addr <= (mem_addr+1) mod MEM_DEPTH, go to FETCH. cs_n stays low and sclk stays low through the gap (3 clk cycles: FETCH, WAIT, LOAD).
    - Else go to HOLD.
  - HOLD: cs_n=0, sclk=0 for CLK_DIV cycles, then go to DONE.
  - DONE: cs_n=1, done=1 for exactly 1 cycle, busy=0 in the same cycle, then go to IDLE.
- Latency:
  - start to cs_n low: 4 clk.
  - Per-word shift time: 2*CLK_DIV*DATA_W clk.
  - For word_count=0: done 2 clk after the start cycle; cs_n and sclk never toggle.
- Boundary conditions:
  - Address wrap: 15 to 0. start_addr >= MEM_DEPTH is reduced modulo MEM_DEPTH on acceptance.
  - start while busy is ignored, with no effect on the current burst.
  - start and done in the same cycle: start is ignored; a new start is accepted only in IDLE, the cycle after DONE.
  - Inputs start_addr and word_count may change during a burst without effect.
  - Reset mid-burst: cs_n=1 and sclk=0 immediately (asynchronously); no done pulse.
- Exactly DATA_W rising sclk edges per word. No sclk edges while cs_n=1.

Optional Feature:
- Macro SPI_STREAM_LSB_FIRST_EN.
  - Defined: each word is shifted LSB-first (bit 0 first; LOAD drives mosi=mem_rdata[0]).
  - Undefined: MSB-first as above.
- All timing is identical in both cases.

Test Plan:
- mem[0]=0x123456, CLK_DIV=2, start_addr=0, word_count=1 -> cs_n low 4 clk after start; 24 sclk rising edges, each 4 clk apart; mosi sampled on the rising edges = 0001_0010_0011_0100_0101_0110; done 1-cycle pulse after 2 clk of HOLD; busy=0.
- start_addr=15 (mem[15]=0x000000), mem[0]=0x123456, word_count=2 -> mem_addr sequence 15, 0; 48 rising edges; mosi 0x000000 then 0x123456; cs_n stays low across the gap.
- word_count=0 -> done pulses 2 clk after start; cs_n stays 1; no sclk edges.
- start pulsed again after word 1 of a 3-word burst -> ignored; exactly 72 sclk edges; one done pulse.
- rst_n=0 asserted at bit 10 of a word -> cs_n=1 and sclk=0 before the next clk edge; busy=0; no done. A following start_addr=1 burst sends 0x654321 correctly.
- With SPI_STREAM_LSB_FIRST_EN, mem[1]=0x654321, word_count=1 -> mosi = 0x654321 bit-reversed (first bits 1,0,0,0,0,1,0,0); timing identical to MSB-first.
